display_scheduler: RTL and testbench
====================================

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clock  input  1  single rising-edge clock
- reset  input  1  asynchronous, active-low reset
REQ-002 Processor requester port SHALL be:
- cpu_valid  input  1  processor requests a display update
- cpu_data  input  32  unsigned value
- cpu_ready  output  1  request accepted this cycle
REQ-003 Debug requester port SHALL be:
- dbg_valid  input  1  debug/switch source requests an update
- dbg_data  input  32  unsigned value
- dbg_ready  output  1  request accepted this cycle
REQ-004 Status outputs SHALL be:
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse when digits update
- source  output  1  origin of displayed value (0 = cpu, 1 = dbg)
- overflow  output  1  displayed value exceeds 99,999,999
REQ-005 Digit outputs SHALL be eight registered 4-bit BCD digits, each 4 bits wide, feeding the seven-segment decoders:
- ones = 10^0
- tens = 10^1
- hundreds = 10^2
- thousands = 10^3
- millions = 10^4
- billions = 10^5
- trillions = 10^6
- gazillions = 10^7

Function
REQ-006 The FSM SHALL have exactly the states IDLE, SHIFT and DONE; busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-007 Grants SHALL be combinational and asserted only in IDLE:
- a requester with valid=1 while the other is idle SHALL be granted;
- with both valid, the requester not granted last SHALL be granted (round-robin);
- the round-robin pointer SHALL reset so that cpu wins the first tie.
REQ-008 A transfer SHALL occur on a rising edge where x_valid=1 and x_ready=1; at most one ready SHALL be high in any cycle.
REQ-009 Requesters SHALL hold valid and data stable until ready; the block SHALL sample data only at the transfer edge.
REQ-010 At the transfer edge, the FSM SHALL load the 32-bit operand and clear a 40-bit (10-digit) BCD accumulator and a 5-bit iteration counter, then enter SHIFT.
REQ-011 SHIFT SHALL perform one double-dabble iteration per clock (add 3 to each BCD nibble >= 5, then shift left one bit, operand MSB first), for exactly 32 iterations, then enter DONE.
REQ-012 On the edge leaving DONE, the block SHALL register the digits, source, overflow and round-robin pointer, pulse done for the following cycle, and return to IDLE.
REQ-013 Latency SHALL be 34 edges from the transfer edge to the digit update; the earliest next transfer SHALL be the edge after the update.
REQ-014 If either upper BCD digit (10^8 or 10^9) is nonzero, overflow SHALL be 1 and all eight digits SHALL be 9; otherwise overflow SHALL be 0 and the digits SHALL be the low eight BCD digits.
REQ-015 Digits, source and overflow SHALL hold their values between updates; valid inputs while busy SHALL be ignored and not queued.
REQ-016 A request arriving in the same cycle as done SHALL be granted normally, because the FSM is already in IDLE.

Reset
REQ-017 Asserting reset (low) at any time, including mid-SHIFT, SHALL immediately:
- force IDLE;
- abort the conversion with no partial update;
- clear all digits to 0;
- set done=0, busy=0, overflow=0 and source=0;
- set the round-robin pointer to favour cpu.
REQ-018 After deassertion, the first rising edge SHALL be able to accept a transfer.

Configuration
REQ-019 With DISPLAY_BLANK_EN defined, each digit above the most significant nonzero digit SHALL be output as 4'hF (blank code); ones SHALL never be blanked, and no blanking SHALL apply when overflow=1.
REQ-020 Without DISPLAY_BLANK_EN, all eight digits SHALL always be output as plain BCD, including leading zeros.

Verification
REQ-021 cpu_data=12345678, cpu_valid=1 from IDLE -> cpu_ready for 1 cycle; after 34 edges digits read 1,2,3,4,5,6,7,8 (gazillions to ones), done for 1 cycle, source=0, overflow=0.
REQ-022 cpu and dbg valid together, repeated three times -> grants in the order cpu, dbg, cpu; source tracks each grant.
REQ-023 dbg_data=32'hFFFFFFFF -> overflow=1, all digits 9; then dbg_data=0 -> overflow=0, all digits 0 (ones=0, others 4'hF with DISPLAY_BLANK_EN).
REQ-024 reset asserted at SHIFT iteration 20 -> immediate IDLE, digits 0, no done pulse; a new request after deassertion completes normally in 34 edges.
REQ-025 cpu_valid pulsed while busy, then dropped -> request ignored; the display keeps the prior value.

Source files
------------

// File: rtl/display_scheduler.sv
// Round-robin arbiter for a processor and a debug requester, feeding a 32-iteration
// double-dabble converter that drives eight registered BCD display digits.
// Optional leading-zero blanking is enabled by defining DISPLAY_BLANK_EN.
module display_scheduler (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_valid,
    input  logic [31:0] cpu_data,
    output logic        cpu_ready,
    input  logic        dbg_valid,
    input  logic [31:0] dbg_data,
    output logic        dbg_ready,
    output logic        busy,
    output logic        done,
    output logic        source,
    output logic        overflow,
    output logic [3:0]  ones,
    output logic [3:0]  tens,
    output logic [3:0]  hundreds,
    output logic [3:0]  thousands,
    output logic [3:0]  millions,
    output logic [3:0]  billions,
    output logic [3:0]  trillions,
    output logic [3:0]  gazillions
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] op_q;
    logic [39:0] bcd_q;
    logic [4:0]  cnt_q;
    logic        pend_src_q;
    logic        prio_dbg_q;
    logic        source_q;
    logic        overflow_q;
    logic        done_q;
    logic [31:0] digits_q;

    logic        idle;
    logic [39:0] bcd_adj;
    logic [39:0] bcd_d;
    logic [31:0] op_d;
    logic [31:0] digits_d;
    logic        overflow_d;

    // prio_dbg_q=0 means the processor wins a tie; it flips to the other requester after each update.
    assign idle      = (state_q == IDLE);
    assign cpu_ready = idle & cpu_valid & (~dbg_valid | ~prio_dbg_q);
    assign dbg_ready = idle & dbg_valid & (~cpu_valid | prio_dbg_q);

    // One double-dabble step: correct every nibble >= 5, then shift the operand MSB in.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        bcd_adj = bcd_q;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_d = {bcd_adj[38:0], op_q[31]};
        op_d  = {op_q[30:0], 1'b0};
    end

    always_comb begin
        overflow_d = |bcd_q[39:32];
        digits_d   = overflow_d ? {8{4'h9}} : bcd_q[31:0];
`ifdef DISPLAY_BLANK_EN
        if (!overflow_d) begin
            logic leading;
            leading = 1'b1;
            for (int i = 7; i >= 1; i--) begin
                if (leading && digits_d[4*i +: 4] == 4'd0) begin
                    digits_d[4*i +: 4] = 4'hF;
                end else begin
                    leading = 1'b0;
                end
            end
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            pend_src_q <= 1'b0;
            prio_dbg_q <= 1'b0;
            source_q   <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            digits_q   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_ready || dbg_ready) begin
                        op_q       <= dbg_ready ? dbg_data : cpu_data;
                        bcd_q      <= '0;
                        cnt_q      <= '0;
                        pend_src_q <= dbg_ready;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q <= bcd_d;
                    op_q  <= op_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    digits_q   <= digits_d;
                    overflow_q <= overflow_d;
                    source_q   <= pend_src_q;
                    prio_dbg_q <= ~pend_src_q;
                    done_q     <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = ~idle;
    assign done     = done_q;
    assign source   = source_q;
    assign overflow = overflow_q;
    assign {gazillions, trillions, billions, millions,
            thousands, hundreds, tens, ones} = digits_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of arbitration and conversion.
module tb_display_scheduler;

    logic        clock     = 1'b0;
    logic        reset     = 1'b0;
    logic        cpu_valid = 1'b0;
    logic        dbg_valid = 1'b0;
    logic [31:0] cpu_data  = '0;
    logic [31:0] dbg_data  = '0;
    logic        cpu_ready, dbg_ready, busy, done, source, overflow;
    logic [3:0]  ones, tens, hundreds, thousands, millions, billions, trillions, gazillions;
    logic [31:0] dut_digits;

    assign dut_digits = {gazillions, trillions, billions, millions,
                         thousands, hundreds, tens, ones};

`ifdef DISPLAY_BLANK_EN
    localparam logic [31:0] ZERO_SHOWN = 32'hFFFF_FFF0;
    localparam logic [31:0] D777_SHOWN = 32'hFFFF_F777;
`else
    localparam logic [31:0] ZERO_SHOWN = 32'h0000_0000;
    localparam logic [31:0] D777_SHOWN = 32'h0000_0777;
`endif

    int checks    = 0;
    int failures  = 0;
    int n_updates = 0;

    // Transaction-level model: edges left until the display update, plus visible state.
    int          m_rem      = 0;
    logic [31:0] m_digits   = '0;
    logic        m_src      = 1'b0;
    logic        m_ovf      = 1'b0;
    logic        m_done     = 1'b0;
    logic        m_last_dbg = 1'b1;
    logic        m_pend_src = 1'b0;
    logic [31:0] m_pend_val = '0;
    logic        exp_cr, exp_dr;
    logic        cpu_took = 1'b0;
    logic        dbg_took = 1'b0;

    display_scheduler dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_valid  (cpu_valid),
        .cpu_data   (cpu_data),
        .cpu_ready  (cpu_ready),
        .dbg_valid  (dbg_valid),
        .dbg_data   (dbg_data),
        .dbg_ready  (dbg_ready),
        .busy       (busy),
        .done       (done),
        .source     (source),
        .overflow   (overflow),
        .ones       (ones),
        .tens       (tens),
        .hundreds   (hundreds),
        .thousands  (thousands),
        .millions   (millions),
        .billions   (billions),
        .trillions  (trillions),
        .gazillions (gazillions)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_digits(input logic [31:0] v);
        logic [31:0]     d;
        longint unsigned x;
        if (v > 32'd99_999_999) return 32'h9999_9999;
        x = longint'(v);
        for (int i = 0; i < 8; i++) begin
            d[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
`ifdef DISPLAY_BLANK_EN
        for (int i = 7; i >= 1; i--) begin
            if (d[4*i +: 4] != 4'd0) break;
            d[4*i +: 4] = 4'hF;
        end
`endif
        return d;
    endfunction

    function automatic logic winner_is_dbg(input logic cv, input logic dv);
        if (cv && dv) return !m_last_dbg;
        return dv;
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 999));
            2:       return 32'($urandom_range(100_000_010, 99_999_990));
            default: return 32'($urandom_range(0, 99_999_999));
        endcase
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_rem      = 0;
            m_digits   = '0;
            m_src      = 1'b0;
            m_ovf      = 1'b0;
            m_done     = 1'b0;
            m_last_dbg = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_digits   = exp_digits(m_pend_val);
                    m_ovf      = (m_pend_val > 32'd99_999_999);
                    m_src      = m_pend_src;
                    m_last_dbg = m_pend_src;
                    m_done     = 1'b1;
                    n_updates++;
                end
            end else if (cpu_valid || dbg_valid) begin
                m_pend_src = winner_is_dbg(cpu_valid, dbg_valid);
                m_pend_val = m_pend_src ? dbg_data : cpu_data;
                m_rem      = 33;
            end
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            exp_dr = (m_rem == 0) && (cpu_valid || dbg_valid) && winner_is_dbg(cpu_valid, dbg_valid);
            exp_cr = (m_rem == 0) && (cpu_valid || dbg_valid) && !winner_is_dbg(cpu_valid, dbg_valid);
            check("cpu_ready", 32'(cpu_ready), 32'(exp_cr));
            check("dbg_ready", 32'(dbg_ready), 32'(exp_dr));
            check("one_ready", 32'(cpu_ready & dbg_ready), 32'd0);
            check("busy",      32'(busy),      32'(m_rem != 0));
            check("done",      32'(done),      32'(m_done));
            check("source",    32'(source),    32'(m_src));
            check("overflow",  32'(overflow),  32'(m_ovf));
            check("digits",    dut_digits,     m_digits);
        end
        cpu_took = cpu_ready;
        dbg_took = dbg_ready;
    end

    task automatic wait_any(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cpu_ready || dbg_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("grant_timeout", 32'(ok), 32'd1);
    endtask

    task automatic measure(output int lat);
        lat = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (done) return;
            @(posedge clock);
            lat++;
        end
    endtask

    task automatic send(input bit is_dbg, input logic [31:0] v, output int lat);
        bit ok;
        @(posedge clock); #1;
        if (is_dbg) begin dbg_valid = 1'b1; dbg_data = v; end
        else        begin cpu_valid = 1'b1; cpu_data = v; end
        @(negedge clock);
        wait_any(ok);
        check("grant_side", 32'(is_dbg ? dbg_ready : cpu_ready), 32'd1);
        @(posedge clock); #1;
        if (is_dbg) dbg_valid = 1'b0; else cpu_valid = 1'b0;
        measure(lat);
    endtask

    initial begin
        int lat;
        bit ok;
        bit exp_dbg;

        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        // Basic conversion from the processor.
        send(1'b0, 32'd12_345_678, lat);
        check("lat_cpu",      32'(lat),      32'd34);
        check("digits_12345678", dut_digits, 32'h1234_5678);
        check("src_cpu",      32'(source),   32'd0);
        check("ovf_cpu",      32'(overflow), 32'd0);
        check("done_pulse",   32'(done),     32'd1);
        @(posedge clock); #1;
        check("done_one_cycle", 32'(done),   32'd0);

        // Overflow saturates to all nines, then a zero value clears it.
        send(1'b1, 32'hFFFF_FFFF, lat);
        check("ovf_set",      32'(overflow), 32'd1);
        check("digits_nines", dut_digits,    32'h9999_9999);
        check("src_dbg",      32'(source),   32'd1);
        send(1'b1, 32'd0, lat);
        check("ovf_clear",    32'(overflow), 32'd0);
        check("digits_zero",  dut_digits,    ZERO_SHOWN);

        // A processor request raised and dropped while busy is ignored.
        send(1'b0, 32'd4321, lat);
        @(posedge clock); #1;
        dbg_valid = 1'b1; dbg_data = 32'd777;
        @(negedge clock);
        wait_any(ok);
        @(posedge clock); #1;
        dbg_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1 cpu_valid = 1'b1; cpu_data = 32'd999;
        repeat (3) @(posedge clock);
        #1 cpu_valid = 1'b0;
        measure(lat);
        repeat (40) @(negedge clock);
        check("ignored_digits", dut_digits,  D777_SHOWN);
        check("ignored_src",    32'(source), 32'd1);
        check("ignored_busy",   32'(busy),   32'd0);

        // Reset in the middle of a conversion.
        @(posedge clock); #1;
        cpu_valid = 1'b1; cpu_data = 32'd87_654_321;
        @(negedge clock);
        wait_any(ok);
        @(posedge clock); #1;
        cpu_valid = 1'b0;
        repeat (20) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check("rst_busy",   32'(busy),     32'd0);
        check("rst_done",   32'(done),     32'd0);
        check("rst_digits", dut_digits,    32'd0);
        check("rst_src",    32'(source),   32'd0);
        check("rst_ovf",    32'(overflow), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        cpu_valid = 1'b1; cpu_data = 32'd11;
        dbg_valid = 1'b1; dbg_data = 32'd22;
        @(negedge clock);
        check("first_edge_cpu", 32'(cpu_ready), 32'd1);
        check("first_edge_dbg", 32'(dbg_ready), 32'd0);

        // Three back-to-back ties alternate cpu, dbg, cpu.
        for (int r = 0; r < 3; r++) begin
            exp_dbg = (r == 1);
            wait_any(ok);
            check("tie_dbg", 32'(dbg_ready), 32'(exp_dbg));
            check("tie_cpu", 32'(cpu_ready), 32'(!exp_dbg));
            @(posedge clock); #1;
            if (r == 2) begin cpu_valid = 1'b0; dbg_valid = 1'b0; end
            else if (exp_dbg) dbg_data = 32'd44;
            else              cpu_data = 32'd33;
            measure(lat);
            check("tie_latency", 32'(lat),    32'd34);
            check("tie_source",  32'(source), 32'(exp_dbg));
        end

        // Randomized traffic from both requesters.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock); #1;
            if (cpu_valid && cpu_took) cpu_valid = 1'b0;
            else if (cpu_valid && m_rem > 0 && $urandom_range(0, 15) == 0) cpu_valid = 1'b0;
            else if (!cpu_valid && $urandom_range(0, 5) == 0) begin
                cpu_valid = 1'b1; cpu_data = rand_val();
            end
            if (dbg_valid && dbg_took) dbg_valid = 1'b0;
            else if (dbg_valid && m_rem > 0 && $urandom_range(0, 15) == 0) dbg_valid = 1'b0;
            else if (!dbg_valid && $urandom_range(0, 5) == 0) begin
                dbg_valid = 1'b1; dbg_data = rand_val();
            end
        end
        @(posedge clock); #1;
        cpu_valid = 1'b0;
        dbg_valid = 1'b0;
        repeat (40) @(posedge clock);
        check("updates_seen", 32'(n_updates > 50), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
